// File: rtl/exe5.sv
// exe5: registered operand selector/combiner.
// Three priority controls (a > b > c) choose between in1, in2, their XOR,
// the complement of in2, or zero; the choice is registered on out1 with a
// single cycle of latency. A synchronous active-low reset clears out1.
module exe5 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic [WIDTH-1:0] out1
);

  logic [WIDTH-1:0] nxt;

  // Priority select of the next output value; a dominates b, b dominates c.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives nxt, so no latch is inferred.
    nxt = '0;
    if (a) begin
      // b and c are not examined here, so unknowns on them cannot leak into out1.
      nxt = in1;
    end else if (b) begin
      nxt = c ? in2 : (in1 ^ in2);
    end else if (c) begin
      nxt = ~in2;
    end
  end

  // Output register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps register updates order-independent across always_ff blocks.
    if (!rst_n) begin
      out1 <= '0;
    end else begin
      out1 <= nxt;
    end
  end

endmodule

// File: tb/tb_exe5.sv
// tb_exe5: self-checking bench for exe5.
// A behavioural model predicts out1 from the selection table and a compare
// process checks it every cycle; directed cases with literal expected values
// pin the model, followed by a randomized run.
module tb_exe5;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             a;
  logic             b;
  logic             c;
  logic [WIDTH-1:0] out1;

  int checks = 0;
  int errors = 0;

  exe5 #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .in2  (in2),
    .a    (a),
    .b    (b),
    .c    (c),
    .out1 (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: out1=%b expected=%b at %0t", name, got, want, $time);
    end
  endtask

  // Selection table written as a lookup on the full control triple.
  function automatic logic [WIDTH-1:0] model_nxt(
    input logic ia, input logic ib, input logic ic,
    input logic [WIDTH-1:0] i1, input logic [WIDTH-1:0] i2);
    if (ia === 1'b1) return i1;
    casez ({ib, ic})
      2'b11:   return i2;
      2'b10:   return i1 ^ i2;
      2'b01:   return ~i2;
      default: return '0;
    endcase
  endfunction

  logic [WIDTH-1:0] exp_q;
  logic             exp_valid = 1'b0;

  // Model register: what out1 must hold after each rising edge.
  always @(posedge clk) begin
    exp_q     <= (rst_n === 1'b1) ? model_nxt(a, b, c, in1, in2) : '0;
    exp_valid <= 1'b1;
  end

  // Compare process: checked on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) check("model", out1, exp_q);
  end

  task automatic drive(input logic r, input logic [WIDTH-1:0] i1,
                       input logic [WIDTH-1:0] i2, input logic ia,
                       input logic ib, input logic ic);
    @(negedge clk);
    rst_n = r; in1 = i1; in2 = i2; a = ia; b = ib; c = ic;
  endtask

  task automatic expect_after_edge(input string name, input logic [WIDTH-1:0] want);
    @(posedge clk);
    #1;
    check(name, out1, want);
  endtask

  initial begin
    rst_n = 1'b0; in1 = 3'b101; in2 = 3'b010; a = 1'b1; b = 1'b1; c = 1'b1;

    // Reset held for two edges with all controls high.
    expect_after_edge("reset_edge1", 3'b000);
    drive(1'b0, 3'b101, 3'b010, 1'b1, 1'b1, 1'b1);
    expect_after_edge("reset_edge2", 3'b000);

    // All controls low selects zero.
    drive(1'b1, 3'b101, 3'b010, 1'b0, 1'b0, 1'b0);
    expect_after_edge("zero_sel", 3'b000);

    // a passes in1 and wins over b and c.
    drive(1'b1, 3'b101, 3'b010, 1'b1, 1'b0, 1'b0);
    expect_after_edge("a_only", 3'b101);
    drive(1'b1, 3'b101, 3'b010, 1'b1, 1'b1, 1'b1);
    expect_after_edge("a_wins", 3'b101);

    // b with c passes in2; b alone gives the XOR.
    drive(1'b1, 3'b101, 3'b010, 1'b0, 1'b1, 1'b1);
    expect_after_edge("b_c_in2", 3'b010);
    drive(1'b1, 3'b101, 3'b010, 1'b0, 1'b1, 1'b0);
    expect_after_edge("b_xor", 3'b111);

    // c alone gives ~in2; then XOR with different operands.
    drive(1'b1, 3'b110, 3'b011, 1'b0, 1'b0, 1'b1);
    expect_after_edge("c_not_in2", 3'b100);
    drive(1'b1, 3'b110, 3'b011, 1'b0, 1'b1, 1'b0);
    expect_after_edge("b_xor2", 3'b101);

    // Unknowns on controls that a makes irrelevant.
    drive(1'b1, 3'b011, 3'b100, 1'b1, 1'bx, 1'bx);
    expect_after_edge("a_with_x", 3'b011);

    // Mid-stream reset pulse.
    drive(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_after_edge("pre_reset", 3'b111);
    drive(1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_after_edge("mid_reset", 3'b000);
    drive(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_after_edge("post_reset", 3'b111);

    // Randomized run with occasional reset pulses; checked by the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(15) != 0), WIDTH'($urandom), WIDTH'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
